// File: rtl/alu_pkg.sv
// Shared ALU encodings: 4-bit ALU control codes, major opcodes and execute-kind tags.
// Used by the execute-stage decoder, the pipeline and the bench.
package alu_pkg;

   typedef enum logic [3:0] {
      ALU_AND  = 4'b0000,
      ALU_OR   = 4'b0001,
      ALU_ADD  = 4'b0010,
      ALU_SLL  = 4'b0011,
      ALU_SUB  = 4'b0100,
      ALU_SRL  = 4'b0101,
      ALU_MUL  = 4'b0110,
      ALU_XOR  = 4'b0111,
      ALU_SLTU = 4'b1000
   } alu_op_t;

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_BR = 7'b1100011;

   localparam logic [6:0] F7_ZERO = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_MUL  = 7'b0000001;

   typedef enum logic [2:0] {
      EX_ALU,
      EX_BRANCH_EQ,
      EX_BRANCH_NE,
      EX_BRANCH_LTU,
      EX_ILLEGAL
   } ex_kind_t;

endpackage

// File: rtl/alu_ex_stage_if.sv
// Instruction-in / ALU-port / result-out bundle of the execute stage.
// slave = the execute stage itself, master = upstream/ALU/consumer side.
interface alu_ex_stage_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [6:0]      in_opcode;
   logic [2:0]      in_funct3;
   logic [6:0]      in_funct7;
   logic [XLEN-1:0] in_rs1;
   logic [XLEN-1:0] in_rs2;
   logic [XLEN-1:0] in_imm;
   logic [XLEN-1:0] in_pc;
   logic [4:0]      in_rd;

   logic [XLEN-1:0] alu_in1;
   logic [XLEN-1:0] alu_in2;
   logic [3:0]      alu_control;
   logic [XLEN-1:0] alu_result;
   logic            alu_zero;

   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_result;
   logic [4:0]      out_rd;
   logic            out_br_taken;
   logic [XLEN-1:0] out_br_target;
   logic            out_illegal;

   modport slave (
      input  in_valid, in_opcode, in_funct3, in_funct7, in_rs1, in_rs2, in_imm, in_pc, in_rd,
      output in_ready,
      output alu_in1, alu_in2, alu_control,
      input  alu_result, alu_zero,
      output out_valid, out_result, out_rd, out_br_taken, out_br_target, out_illegal,
      input  out_ready
   );

   modport master (
      output in_valid, in_opcode, in_funct3, in_funct7, in_rs1, in_rs2, in_imm, in_pc, in_rd,
      input  in_ready,
      input  alu_in1, alu_in2, alu_control,
      output alu_result, alu_zero,
      input  out_valid, out_result, out_rd, out_br_taken, out_br_target, out_illegal,
      output out_ready
   );
endinterface

// File: rtl/alu_decode.sv
// Combinational opcode/funct decode to ALU code, operand select and execute kind.
// Define ALU_EX_MUL_EN to accept R-type MUL (f3=000, f7=0000001); otherwise it is illegal.
module alu_decode
   import alu_pkg::*;
(
   input  logic [6:0] i_opcode,
   input  logic [2:0] i_funct3,
   input  logic [6:0] i_funct7,
   output alu_op_t    o_alu_op,
   output logic       o_use_imm,
   output logic       o_is_shift,
   output ex_kind_t   o_kind
);

   alu_op_t  w_op;
   ex_kind_t w_kind;
   logic     w_legal;
   logic     w_use_imm;
   logic     w_shift;
   logic     w_f7_zero;

   assign w_f7_zero = (i_funct7 == F7_ZERO);

   always_comb begin
      w_op      = ALU_ADD;
      w_kind    = EX_ALU;
      w_legal   = 1'b0;
      w_use_imm = 1'b0;
      w_shift   = 1'b0;
      case (i_opcode)
         OP_R: begin
            case (i_funct3)
               3'b000: begin
                  if (w_f7_zero) begin
                     w_op = ALU_ADD;  w_legal = 1'b1;
                  end else if (i_funct7 == F7_ALT) begin
                     w_op = ALU_SUB;  w_legal = 1'b1;
                  end
`ifdef ALU_EX_MUL_EN
                  else if (i_funct7 == F7_MUL) begin
                     w_op = ALU_MUL;  w_legal = 1'b1;
                  end
`endif
               end
               3'b001: begin w_op = ALU_SLL;  w_shift = 1'b1; w_legal = w_f7_zero; end
               3'b011: begin w_op = ALU_SLTU; w_legal = w_f7_zero; end
               3'b100: begin w_op = ALU_XOR;  w_legal = w_f7_zero; end
               3'b101: begin w_op = ALU_SRL;  w_shift = 1'b1; w_legal = w_f7_zero; end
               3'b110: begin w_op = ALU_OR;   w_legal = w_f7_zero; end
               3'b111: begin w_op = ALU_AND;  w_legal = w_f7_zero; end
               default: w_legal = 1'b0;
            endcase
         end
         OP_I: begin
            w_use_imm = 1'b1;
            case (i_funct3)
               3'b000: begin w_op = ALU_ADD;  w_legal = 1'b1; end
               3'b001: begin w_op = ALU_SLL;  w_shift = 1'b1; w_legal = 1'b1; end
               3'b011: begin w_op = ALU_SLTU; w_legal = 1'b1; end
               3'b100: begin w_op = ALU_XOR;  w_legal = 1'b1; end
               3'b101: begin w_op = ALU_SRL;  w_shift = 1'b1; w_legal = w_f7_zero; end
               3'b110: begin w_op = ALU_OR;   w_legal = 1'b1; end
               3'b111: begin w_op = ALU_AND;  w_legal = 1'b1; end
               default: w_legal = 1'b0;
            endcase
         end
         OP_BR: begin
            // Branches reuse the ALU compare; taken is resolved from zero_flag later.
            case (i_funct3)
               3'b000: begin w_op = ALU_SUB;  w_kind = EX_BRANCH_EQ;  w_legal = 1'b1; end
               3'b001: begin w_op = ALU_SUB;  w_kind = EX_BRANCH_NE;  w_legal = 1'b1; end
               3'b110: begin w_op = ALU_SLTU; w_kind = EX_BRANCH_LTU; w_legal = 1'b1; end
               default: w_legal = 1'b0;
            endcase
         end
         default: w_legal = 1'b0;
      endcase
   end

   assign o_alu_op   = w_legal ? w_op      : ALU_ADD;
   assign o_kind     = w_legal ? w_kind    : EX_ILLEGAL;
   assign o_use_imm  = w_legal ? w_use_imm : 1'b0;
   assign o_is_shift = w_legal ? w_shift   : 1'b0;

endmodule

// File: rtl/alu_ex_stage.sv
// Execute front end: stage 1 drives the external ALU, stage 2 registers result/branch; 2-cycle latency, full throughput.
// in_ready drops only when both stages hold data and out_ready is low. ALU_EX_MUL_EN enables MUL decode.
module alu_ex_stage
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic          clk,
   input  logic          rst,
   alu_ex_stage_if.slave ex_if
);

   alu_op_t         w_dec_op;
   logic            w_dec_use_imm;
   logic            w_dec_shift;
   ex_kind_t        w_dec_kind;
   logic [XLEN-1:0] w_op2;
   logic [XLEN-1:0] w_in2;
   logic            w_in_fire;
   logic            w_out_fire;
   logic            w_s2_load;

   logic            r_s1_vld;
   logic [XLEN-1:0] r_in1;
   logic [XLEN-1:0] r_in2;
   alu_op_t         r_ctrl;
   ex_kind_t        r_kind;
   logic [4:0]      r_rd;
   logic [XLEN-1:0] r_tgt;

   logic [XLEN-1:0] w_s2_res;
   logic [4:0]      w_s2_rd;
   logic            w_s2_taken;
   logic            w_s2_ill;

   logic            r_s2_vld;
   logic [XLEN-1:0] r_res;
   logic [4:0]      r_rd2;
   logic            r_taken;
   logic [XLEN-1:0] r_tgt2;
   logic            r_ill;

   alu_decode u_decode (
      .i_opcode   (ex_if.in_opcode),
      .i_funct3   (ex_if.in_funct3),
      .i_funct7   (ex_if.in_funct7),
      .o_alu_op   (w_dec_op),
      .o_use_imm  (w_dec_use_imm),
      .o_is_shift (w_dec_shift),
      .o_kind     (w_dec_kind)
   );

   assign w_op2 = w_dec_use_imm ? ex_if.in_imm : ex_if.in_rs2;
   assign w_in2 = w_dec_shift ? {{(XLEN-5){1'b0}}, w_op2[4:0]} : w_op2;

   assign ex_if.in_ready = !r_s1_vld || !r_s2_vld || ex_if.out_ready;
   assign w_in_fire      = ex_if.in_valid && ex_if.in_ready;
   assign w_out_fire     = r_s2_vld && ex_if.out_ready;
   assign w_s2_load      = r_s1_vld && (!r_s2_vld || ex_if.out_ready);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_vld <= 1'b0;
         r_in1    <= '0;
         r_in2    <= '0;
         r_ctrl   <= ALU_ADD;
         r_kind   <= EX_ALU;
         r_rd     <= '0;
         r_tgt    <= '0;
      end else if (w_in_fire) begin
         r_s1_vld <= 1'b1;
         r_in1    <= ex_if.in_rs1;
         r_in2    <= w_in2;
         r_ctrl   <= w_dec_op;
         r_kind   <= w_dec_kind;
         r_rd     <= ex_if.in_rd;
         r_tgt    <= ex_if.in_pc + ex_if.in_imm;
      end else if (w_s2_load) begin
         r_s1_vld <= 1'b0;
      end
   end

   assign ex_if.alu_in1     = r_in1;
   assign ex_if.alu_in2     = r_in2;
   assign ex_if.alu_control = r_ctrl;

   // Branches and illegal ops carry no writeback: result and rd forced to zero.
   always_comb begin
      w_s2_res   = ex_if.alu_result;
      w_s2_rd    = r_rd;
      w_s2_taken = 1'b0;
      w_s2_ill   = 1'b0;
      case (r_kind)
         EX_BRANCH_EQ: begin
            w_s2_res = '0; w_s2_rd = '0; w_s2_taken = ex_if.alu_zero;
         end
         EX_BRANCH_NE, EX_BRANCH_LTU: begin
            w_s2_res = '0; w_s2_rd = '0; w_s2_taken = !ex_if.alu_zero;
         end
         EX_ILLEGAL: begin
            w_s2_res = '0; w_s2_rd = '0; w_s2_ill = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s2_vld <= 1'b0;
         r_res    <= '0;
         r_rd2    <= '0;
         r_taken  <= 1'b0;
         r_tgt2   <= '0;
         r_ill    <= 1'b0;
      end else if (w_s2_load) begin
         r_s2_vld <= 1'b1;
         r_res    <= w_s2_res;
         r_rd2    <= w_s2_rd;
         r_taken  <= w_s2_taken;
         r_tgt2   <= r_tgt;
         r_ill    <= w_s2_ill;
      end else if (w_out_fire) begin
         r_s2_vld <= 1'b0;
      end
   end

   assign ex_if.out_valid     = r_s2_vld;
   assign ex_if.out_result    = r_res;
   assign ex_if.out_rd        = r_rd2;
   assign ex_if.out_br_taken  = r_taken;
   assign ex_if.out_br_target = r_tgt2;
   assign ex_if.out_illegal   = r_ill;

endmodule

// File: tb/tb_alu_ex_stage.sv
// Directed bench for alu_ex_stage: behavioural ALU on the ALU ports, queue scoreboard checked by a monitor.
module tb_alu_ex_stage;
   import alu_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_ex_stage_if #(.XLEN(32)) ex_if ();
   alu_ex_stage #(.XLEN(32)) u_dut (.clk(clk), .rst(rst), .ex_if(ex_if));

   typedef struct packed {
      logic [31:0] res;
      logic [4:0]  rd;
      logic        taken;
      logic [31:0] tgt;
      logic        ill;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   logic stalled = 1'b0;
   exp_t held;
   logic [31:0] alu_r;

   // Behavioural ALU standing in for the external combinational alu.
   always_comb begin
      alu_r = 32'h0;
      case (ex_if.alu_control)
         4'b0000: alu_r = ex_if.alu_in1 & ex_if.alu_in2;
         4'b0001: alu_r = ex_if.alu_in1 | ex_if.alu_in2;
         4'b0010: alu_r = ex_if.alu_in1 + ex_if.alu_in2;
         4'b0011: alu_r = ex_if.alu_in1 << ex_if.alu_in2[4:0];
         4'b0100: alu_r = ex_if.alu_in1 - ex_if.alu_in2;
         4'b0101: alu_r = ex_if.alu_in1 >> ex_if.alu_in2[4:0];
         4'b0110: alu_r = ex_if.alu_in1 * ex_if.alu_in2;
         4'b0111: alu_r = ex_if.alu_in1 ^ ex_if.alu_in2;
         4'b1000: alu_r = {31'h0, ex_if.alu_in1 < ex_if.alu_in2};
         default: alu_r = 32'h0;
      endcase
   end
   assign ex_if.alu_result = alu_r;
   assign ex_if.alu_zero   = (alu_r == 32'h0);

   task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, expv);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] res, input logic [4:0] rd, input logic taken,
                               input logic [31:0] tgt, input logic ill);
      mk = '{res: res, rd: rd, taken: taken, tgt: tgt, ill: ill};
   endfunction

   function automatic exp_t cur();
      cur = '{res: ex_if.out_result, rd: ex_if.out_rd, taken: ex_if.out_br_taken,
              tgt: ex_if.out_br_target, ill: ex_if.out_illegal};
   endfunction

   // Monitor: pops on every output transfer; also checks outputs hold while stalled.
   always @(negedge clk) begin
      if (rst) begin
         stalled <= 1'b0;
      end else begin
         if (stalled) chk("hold_stable", cur(), held);
         if (ex_if.out_valid && ex_if.out_ready) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL extra_output: got %0h expected none", cur());
            end else begin
               chk("out_txn", cur(), sb.pop_front());
            end
         end
         stalled <= ex_if.out_valid && !ex_if.out_ready;
         held    <= cur();
      end
   end

   task automatic send(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                       input logic [31:0] pc, input logic [4:0] rd, input logic [3:0] e_ctrl,
                       input exp_t e);
      int n = 0;
      @(negedge clk);
      ex_if.in_valid  = 1'b1;
      ex_if.in_opcode = opc;
      ex_if.in_funct3 = f3;
      ex_if.in_funct7 = f7;
      ex_if.in_rs1    = rs1;
      ex_if.in_rs2    = rs2;
      ex_if.in_imm    = imm;
      ex_if.in_pc     = pc;
      ex_if.in_rd     = rd;
      while (!ex_if.in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         n_cmp++;
         n_bad++;
         $display("FAIL accept_timeout: got in_ready=0 for %0d cycles expected accept", n);
         ex_if.in_valid = 1'b0;
      end else begin
         sb.push_back(e);
         @(posedge clk);
         #1;
         ex_if.in_valid = 1'b0;
         chk("alu_control", ex_if.alu_control, e_ctrl);
      end
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      chk("drain_empty", sb.size(), 0);
   endtask

   initial begin
      ex_if.in_valid  = 1'b0;
      ex_if.in_opcode = '0;
      ex_if.in_funct3 = '0;
      ex_if.in_funct7 = '0;
      ex_if.in_rs1    = '0;
      ex_if.in_rs2    = '0;
      ex_if.in_imm    = '0;
      ex_if.in_pc     = '0;
      ex_if.in_rd     = '0;
      ex_if.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready",  ex_if.in_ready, 1);
      chk("rst_out_valid", ex_if.out_valid, 0);
      chk("rst_out_bus",   cur(), 0);
      chk("rst_alu_in1",   ex_if.alu_in1, 0);
      chk("rst_alu_in2",   ex_if.alu_in2, 0);
      chk("rst_alu_ctrl",  ex_if.alu_control, 4'b0010);
      rst = 1'b0;

      // ADD with latency probe
      send(OP_R, 3'b000, 7'h00, 5, 7, 0, 0, 3, 4'b0010, mk(12, 3, 0, 0, 0));
      chk("lat_accept_edge", ex_if.out_valid, 0);
      @(posedge clk); #1;
      chk("lat_next_edge", ex_if.out_valid, 1);

      send(OP_I, 3'b101, 7'h00, 32'h80, 0, 32'h424, 0, 7, 4'b0101, mk(32'h08, 7, 0, 32'h424, 0));
      chk("srli_alu_in2", ex_if.alu_in2, 4);
      send(OP_R, 3'b000, 7'h20, 20, 7, 0, 0, 4, 4'b0100, mk(13, 4, 0, 0, 0));
      send(OP_R, 3'b001, 7'h00, 1, 35, 0, 0, 5, 4'b0011, mk(8, 5, 0, 0, 0));
      chk("sll_alu_in2", ex_if.alu_in2, 3);
      send(OP_R, 3'b011, 7'h00, 3, 9, 0, 0, 6, 4'b1000, mk(1, 6, 0, 0, 0));
      send(OP_I, 3'b100, 7'h00, 32'hFF, 0, 32'h0F, 0, 7, 4'b0111, mk(32'hF0, 7, 0, 32'h0F, 0));
      send(OP_I, 3'b110, 7'h00, 32'hF0, 0, 32'h0F, 0, 8, 4'b0001, mk(32'hFF, 8, 0, 32'h0F, 0));
      send(OP_I, 3'b111, 7'h00, 32'hF0F0, 0, 32'hFF, 0, 9, 4'b0000, mk(32'hF0, 9, 0, 32'hFF, 0));

      // Branches
      send(OP_BR, 3'b000, 7'h00, 9, 9, 32'h20, 32'h100, 5, 4'b0100, mk(0, 0, 1, 32'h120, 0));
      send(OP_BR, 3'b001, 7'h00, 9, 9, 32'h20, 32'h100, 5, 4'b0100, mk(0, 0, 0, 32'h120, 0));
      send(OP_BR, 3'b110, 7'h00, 3, 9, 32'hFFFF_FFF0, 32'h200, 5, 4'b1000, mk(0, 0, 1, 32'h1F0, 0));

      // Illegal encodings, followed by a legal op to show the pipe keeps moving
      send(7'b0000011, 3'b000, 7'h00, 1, 2, 4, 8, 9, 4'b0010, mk(0, 0, 0, 12, 1));
      send(OP_R, 3'b010, 7'h00, 1, 2, 0, 0, 9, 4'b0010, mk(0, 0, 0, 0, 1));
      send(OP_BR, 3'b010, 7'h00, 1, 2, 0, 0, 9, 4'b0010, mk(0, 0, 0, 0, 1));
      send(OP_R, 3'b000, 7'h00, 2, 2, 0, 0, 10, 4'b0010, mk(4, 10, 0, 0, 0));

`ifdef ALU_EX_MUL_EN
      send(OP_R, 3'b000, 7'h01, 6, 7, 0, 0, 11, 4'b0110, mk(42, 11, 0, 0, 0));
`else
      send(OP_R, 3'b000, 7'h01, 6, 7, 0, 0, 11, 4'b0010, mk(0, 0, 0, 0, 1));
`endif
      drain();

      // Backpressure: two accepts fill the pipe, then in_ready must drop
      @(posedge clk); #1;
      ex_if.out_ready = 1'b0;
      send(OP_R, 3'b000, 7'h00, 1, 1, 0, 0, 1, 4'b0010, mk(2, 1, 0, 0, 0));
      send(OP_R, 3'b000, 7'h00, 2, 2, 0, 0, 2, 4'b0010, mk(4, 2, 0, 0, 0));
      chk("bp_in_ready_low", ex_if.in_ready, 0);
      fork
         begin
            send(OP_R, 3'b000, 7'h00, 3, 3, 0, 0, 3, 4'b0010, mk(6, 3, 0, 0, 0));
            send(OP_R, 3'b000, 7'h00, 10, 20, 0, 0, 4, 4'b0010, mk(30, 4, 0, 0, 0));
         end
         begin
            repeat (3) @(posedge clk);
            #2;
            ex_if.out_ready = 1'b1;
         end
      join
      drain();

      // Reset with both stages full discards everything
      @(posedge clk); #1;
      ex_if.out_ready = 1'b0;
`ifdef ALU_EX_MUL_EN
      send(OP_R, 3'b000, 7'h01, 6, 7, 0, 0, 11, 4'b0110, mk(42, 11, 0, 0, 0));
`else
      send(OP_R, 3'b000, 7'h01, 6, 7, 0, 0, 11, 4'b0010, mk(0, 0, 0, 0, 1));
`endif
      send(OP_R, 3'b000, 7'h00, 1, 1, 0, 0, 12, 4'b0010, mk(2, 12, 0, 0, 0));
      chk("pre_rst_out_valid", ex_if.out_valid, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst_out_valid", ex_if.out_valid, 0);
      chk("midrst_in_ready",  ex_if.in_ready, 1);
      chk("midrst_out_bus",   cur(), 0);
      chk("midrst_alu_ctrl",  ex_if.alu_control, 4'b0010);
      sb.delete();
      rst = 1'b0;
      ex_if.out_ready = 1'b1;

      send(OP_R, 3'b111, 7'h00, 32'hC, 32'hA, 0, 0, 13, 4'b0000, mk(32'h8, 13, 0, 0, 0));
      drain();

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
